// File: rtl/or10_reset_pkg.sv
// Shared encodings for the OR10 reset sequencer: sequencing states and reset-cause codes.

package or10_reset_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        PERIPH_RUN = 2'd1,
        RUN        = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_PORT = 2'd1,
        CAUSE_EXT  = 2'd2
    } reset_cause_e;

endpackage

// File: rtl/or10_sync_chain.sv
// Plain flop chain for bringing an asynchronous level into the clock domain.
// Synchronous active-high reset clears every stage to 0.

module or10_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 2) begin : gen_stages_err
        $error("or10_sync_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/or10_reset_sequencer.sv
// Staged reset release for the OR10 SoC: peripherals first, CPU a fixed delay later.
// Define OR10_RESET_SEQ_RUN_COUNTER_EN to add the saturating run_cycles output.

module or10_reset_sequencer
    import or10_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES      = 16,
    parameter int unsigned CPU_DELAY_CYCLES = 4,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned CNT_WIDTH        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ext_reset_req_async,
    output logic        periph_reset,
    output logic        cpu_reset,
    output logic        reset_done,
    output logic [1:0]  reset_cause
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
    ,
    output logic [31:0] run_cycles
`endif
);

    if (HOLD_CYCLES < 1 || (HOLD_CYCLES >> CNT_WIDTH) != 0) begin : gen_hold_err
        $error("or10_reset_sequencer: HOLD_CYCLES out of range");
    end
    if ((CPU_DELAY_CYCLES >> CNT_WIDTH) != 0) begin : gen_delay_err
        $error("or10_reset_sequencer: CPU_DELAY_CYCLES out of range");
    end

    localparam logic [CNT_WIDTH-1:0] HoldLast  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DelayLast = CNT_WIDTH'(CPU_DELAY_CYCLES - 1);

    logic                 req_s;
    seq_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 periph_q;
    logic                 cpu_q;
    logic                 done_q;
    reset_cause_e         cause_q;

    or10_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (ext_reset_req_async),
        .q_o   (req_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            done_q   <= 1'b0;
            cause_q  <= CAUSE_PORT;
        end else if (req_s) begin
            // A held request pins the counter, so release timing starts when req_s drops.
            state_q  <= HOLD;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            done_q   <= 1'b0;
            cause_q  <= CAUSE_EXT;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HoldLast) begin
                        cnt_q    <= '0;
                        periph_q <= 1'b0;
                        if (CPU_DELAY_CYCLES == 0) begin
                            cpu_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            state_q <= PERIPH_RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                PERIPH_RUN: begin
                    if (cnt_q == DelayLast) begin
                        cnt_q   <= '0;
                        cpu_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state_q  <= HOLD;
                    cnt_q    <= '0;
                    periph_q <= 1'b1;
                    cpu_q    <= 1'b1;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign periph_reset = periph_q;
    assign cpu_reset    = cpu_q;
    assign reset_done   = done_q;
    assign reset_cause  = cause_q;

`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
    logic [31:0] run_q;

    always_ff @(posedge clock) begin
        if (reset || req_s || state_q == HOLD) begin
            run_q <= '0;
        end else if (state_q == RUN && run_q != 32'hFFFF_FFFF) begin
            run_q <= run_q + 32'd1;
        end
    end

    assign run_cycles = run_q;
`endif

endmodule

// File: tb/tb_or10_reset_sequencer.sv
// Scoreboard bench for or10_reset_sequencer: three parameterisations driven in lockstep
// against a model based on edges elapsed since the last active reset source.

module tb_or10_reset_sequencer;

    localparam int HOLD_V  [3] = '{16, 16, 1};
    localparam int DELAY_V [3] = '{4, 0, 4};

    logic clk;
    logic reset;
    logic ext_req;

    logic [2:0]      periph;
    logic [2:0]      cpu;
    logic [2:0]      done;
    logic [2:0][1:0] cause;
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
    logic [2:0][31:0] run_cyc;
`endif

    typedef struct packed {
        logic [2:0][4:0]  st;
        logic [2:0][31:0] run;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_chk;
    exp_t        e_new;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Model state
    int          since    = 0;
    logic [1:0]  ms       = 2'b00;
    logic        req_pre;
    logic [1:0]  m_cause  = 2'd1;
    logic [31:0] m_run [3] = '{32'd0, 32'd0, 32'd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    or10_reset_sequencer u_dut (
        .clock               (clk),
        .reset               (reset),
        .ext_reset_req_async (ext_req),
        .periph_reset        (periph[0]),
        .cpu_reset           (cpu[0]),
        .reset_done          (done[0]),
        .reset_cause         (cause[0])
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
        ,
        .run_cycles          (run_cyc[0])
`endif
    );

    or10_reset_sequencer #(
        .CPU_DELAY_CYCLES (0)
    ) u_d0 (
        .clock               (clk),
        .reset               (reset),
        .ext_reset_req_async (ext_req),
        .periph_reset        (periph[1]),
        .cpu_reset           (cpu[1]),
        .reset_done          (done[1]),
        .reset_cause         (cause[1])
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
        ,
        .run_cycles          (run_cyc[1])
`endif
    );

    or10_reset_sequencer #(
        .HOLD_CYCLES (1)
    ) u_h1 (
        .clock               (clk),
        .reset               (reset),
        .ext_reset_req_async (ext_req),
        .periph_reset        (periph[2]),
        .cpu_reset           (cpu[2]),
        .reset_done          (done[2]),
        .reset_cause         (cause[2])
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
        ,
        .run_cycles          (run_cyc[2])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: outputs depend only on edges since a source was last active.
    always @(posedge clk) begin
        cyc++;
        req_pre = ms[1];
        ms = reset ? 2'b00 : {ms[0], ext_req};
        if (reset || req_pre) begin
            since   = 0;
            m_cause = reset ? 2'd1 : 2'd2;
        end else if (since < 1000000) begin
            since++;
        end
        for (int i = 0; i < 3; i++) begin
            if (since == 0) begin
                m_run[i] = 32'd0;
            end else if (since > HOLD_V[i] + DELAY_V[i] && m_run[i] != 32'hFFFF_FFFF) begin
                m_run[i] = m_run[i] + 32'd1;
            end
            e_new.st[i] = {since < HOLD_V[i], since < HOLD_V[i] + DELAY_V[i],
                           !(since < HOLD_V[i] + DELAY_V[i]), m_cause};
            e_new.run[i] = m_run[i];
        end
        sb_q.push_back(e_new);
    end

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            e_chk = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("inst%0d {periph,cpu,done,cause}", i),
                         32'({periph[i], cpu[i], done[i], cause[i]}), 32'(e_chk.st[i]));
`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
                check_eq($sformatf("inst%0d run_cycles", i), run_cyc[i], e_chk.run[i]);
`endif
            end
        end
    end

    initial begin
        reset   = 1'b1;
        ext_req = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(30);

        // One-cycle external request pulse while running
        ext_req = 1'b1;
        cycles(1);
        ext_req = 1'b0;
        cycles(40);

        // Long request: release timed from req_s falling
        ext_req = 1'b1;
        cycles(50);
        ext_req = 1'b0;
        cycles(40);

        // Reset sampled on the second PERIPH_RUN edge of the default instance
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(17);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(30);

        // Both sources together: port reset wins the cause
        reset   = 1'b1;
        ext_req = 1'b1;
        cycles(5);
        reset = 1'b0;
        cycles(3);
        ext_req = 1'b0;
        cycles(40);

        // Random request activity
        for (int k = 0; k < 8; k++) begin
            ext_req = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 25));
        end
        ext_req = 1'b0;
        cycles(40);

`ifdef OR10_RESET_SEQ_RUN_COUNTER_EN
        // Saturation: preload near the top, expect it to stick at all-ones
        #1;
        force u_dut.run_q = 32'hFFFF_FFFE;
        m_run[0] = 32'hFFFF_FFFE;
        #3;
        release u_dut.run_q;
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(30);
`endif

        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
